// File: rtl/mv_tile_ctrl.sv
// mv_tile_ctrl: job sequencer for the matrix-vector co-accelerator.
// Streams cfg_k weight/vector reads per tile into the PE core, waits out
// read + PE latency, then writes one result row; repeats for cfg_tiles tiles.
module mv_tile_ctrl #(
  parameter int unsigned ARRAY_SIZE = 32,
  parameter int unsigned MAX_K      = 256,
  parameter int unsigned W_AW       = 10,
  parameter int unsigned V_AW       = 10,
  parameter int unsigned O_AW       = 5,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned PE_LAT     = 2,
  parameter int unsigned CW         = $clog2(MAX_K + 1)
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            start,
  input  logic            abort,
  input  logic [CW-1:0]   cfg_k,
  input  logic [O_AW:0]   cfg_tiles,
  input  logic [W_AW-1:0] cfg_w_base,
  input  logic [V_AW-1:0] cfg_v_base,
  input  logic [O_AW-1:0] cfg_o_base,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            err_cfg,
  output logic [W_AW-1:0] sram_w_raddr,
  output logic [V_AW-1:0] sram_v_raddr,
  output logic            alu_start,
  output logic [CW-1:0]   cycle_num,
  output logic            outcome_we,
  output logic [O_AW-1:0] outcome_waddr,
  output logic [O_AW:0]   tile_idx
);

  localparam int unsigned TW        = O_AW + 1;
  localparam int unsigned DRAIN_LEN = RD_LAT + PE_LAT;
  localparam int unsigned DW        = $clog2(DRAIN_LEN + 1);
  // Degenerate parameter sets make every config illegal instead of misbehaving.
  localparam bit          PARAM_OK  = (ARRAY_SIZE > 0) && (RD_LAT >= 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [TW-1:0]   tile_d;
  logic [W_AW-1:0] w_d;
  logic [V_AW-1:0] v_d;
  logic [CW-1:0]   k_q, k_d;
  logic [TW-1:0]   tiles_q, tiles_d;
  logic [V_AW-1:0] v_base_q, v_base_d;
  logic [O_AW-1:0] o_base_q, o_base_d;
  logic            busy_d, done_d, aborted_d, err_d;
  logic            iss_q, iss_d;
  logic [CW-1:0]   num_q, num_d;
  logic            we_d;
  logic [O_AW-1:0] waddr_d;
  logic            flush;
  logic            cfg_legal;

  // Read-latency delay line carrying issue-valid and beat number to the PE.
  logic [RD_LAT-1:0] dl_v;
  logic [CW-1:0]     dl_n [RD_LAT];

  assign alu_start = dl_v[RD_LAT-1];
  assign cycle_num = dl_n[RD_LAT-1];

  // Next-state, counter and next-output logic.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    drain_d   = drain_q;
    tile_d    = tile_idx;
    w_d       = sram_w_raddr;
    v_d       = sram_v_raddr;
    k_d       = k_q;
    tiles_d   = tiles_q;
    v_base_d  = v_base_q;
    o_base_d  = o_base_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = 1'b0;
    flush     = 1'b0;

    cfg_legal = PARAM_OK &&
                (cfg_k != '0) && (cfg_k <= CW'(MAX_K)) &&
                (cfg_tiles != '0) && (cfg_tiles <= TW'(2 ** O_AW));

    if (state_q != S_IDLE && abort) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
      flush     = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            if (cfg_legal) begin
              state_d  = S_ISSUE;
              beat_d   = '0;
              tile_d   = '0;
              w_d      = cfg_w_base;
              v_d      = cfg_v_base;
              k_d      = cfg_k;
              tiles_d  = cfg_tiles;
              v_base_d = cfg_v_base;
              o_base_d = cfg_o_base;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (beat_q == k_q - CW'(1)) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            beat_d = beat_q + CW'(1);
            w_d    = sram_w_raddr + W_AW'(1);
            v_d    = sram_v_raddr + V_AW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_q == DW'(DRAIN_LEN - 1)) begin
            state_d = S_WRITE;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
        S_WRITE: begin
          if (tile_idx + TW'(1) < tiles_q) begin
            state_d = S_ISSUE;
            beat_d  = '0;
            tile_d  = tile_idx + TW'(1);
            w_d     = sram_w_raddr + W_AW'(1);
            v_d     = v_base_q;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d  = (state_d != S_IDLE);
    iss_d   = (state_d == S_ISSUE);
    num_d   = iss_d ? beat_d + CW'(1) : '0;
    we_d    = (state_d == S_WRITE);
    waddr_d = we_d ? o_base_q + tile_d[O_AW-1:0] : '0;
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      drain_q       <= '0;
      k_q           <= '0;
      tiles_q       <= '0;
      v_base_q      <= '0;
      o_base_q      <= '0;
      iss_q         <= 1'b0;
      num_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      err_cfg       <= 1'b0;
      sram_w_raddr  <= '0;
      sram_v_raddr  <= '0;
      outcome_we    <= 1'b0;
      outcome_waddr <= '0;
      tile_idx      <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      drain_q       <= drain_d;
      k_q           <= k_d;
      tiles_q       <= tiles_d;
      v_base_q      <= v_base_d;
      o_base_q      <= o_base_d;
      iss_q         <= iss_d;
      num_q         <= num_d;
      busy          <= busy_d;
      done          <= done_d;
      aborted       <= aborted_d;
      err_cfg       <= err_d;
      sram_w_raddr  <= w_d;
      sram_v_raddr  <= v_d;
      outcome_we    <= we_d;
      outcome_waddr <= waddr_d;
      tile_idx      <= tile_d;
    end
  end

  // Delay line shift; reset and abort both empty it so no stray beats reach the PE.
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      dl_v <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) dl_n[i] <= '0;
    end else begin
      dl_v[0] <= iss_q;
      dl_n[0] <= num_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_n[i] <= dl_n[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mv_tile_ctrl.sv
// Bench for mv_tile_ctrl: per-cycle reference model built from tile timing arithmetic.
module tb_mv_tile_ctrl;

  localparam int unsigned MAX_K  = 256;
  localparam int unsigned W_AW   = 4;
  localparam int unsigned V_AW   = 10;
  localparam int unsigned O_AW   = 5;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned PE_LAT = 2;
  localparam int unsigned CW     = $clog2(MAX_K + 1);

  logic            clk = 1'b0;
  logic            srst, start, abort;
  logic [CW-1:0]   cfg_k;
  logic [O_AW:0]   cfg_tiles;
  logic [W_AW-1:0] cfg_w_base;
  logic [V_AW-1:0] cfg_v_base;
  logic [O_AW-1:0] cfg_o_base;
  logic            busy, done, aborted, err_cfg;
  logic [W_AW-1:0] sram_w_raddr;
  logic [V_AW-1:0] sram_v_raddr;
  logic            alu_start;
  logic [CW-1:0]   cycle_num;
  logic            outcome_we;
  logic [O_AW-1:0] outcome_waddr;
  logic [O_AW:0]   tile_idx;

  int vecs = 0;
  int miss = 0;
  int cur_c = 0;

  mv_tile_ctrl #(
    .ARRAY_SIZE(32), .MAX_K(MAX_K), .W_AW(W_AW), .V_AW(V_AW), .O_AW(O_AW),
    .RD_LAT(RD_LAT), .PE_LAT(PE_LAT)
  ) dut (
    .clk(clk), .srst(srst), .start(start), .abort(abort),
    .cfg_k(cfg_k), .cfg_tiles(cfg_tiles), .cfg_w_base(cfg_w_base),
    .cfg_v_base(cfg_v_base), .cfg_o_base(cfg_o_base),
    .busy(busy), .done(done), .aborted(aborted), .err_cfg(err_cfg),
    .sram_w_raddr(sram_w_raddr), .sram_v_raddr(sram_v_raddr),
    .alu_start(alu_start), .cycle_num(cycle_num),
    .outcome_we(outcome_we), .outcome_waddr(outcome_waddr), .tile_idx(tile_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cur_c, obs, exp);
    end
  endtask

  // Advance one clock; land on the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_cfg();
    cfg_k      = CW'($urandom);
    cfg_tiles  = (O_AW+1)'($urandom);
    cfg_w_base = W_AW'($urandom);
    cfg_v_base = V_AW'($urandom);
    cfg_o_base = O_AW'($urandom);
  endtask

  // Launch a job in the current cycle and check every cycle until done,
  // or until the cycle after an abort (term_rst=0) / srst (term_rst=1) at term_at.
  task automatic run_job(input int k, input int tiles, input int wb, input int vb,
                         input int ob, input bit hold, input int term_at, input bit term_rst);
    int p, t_all, c_end, off, t, e_w, e_v, e_num, e_wa, e_tile;
    bit term, e_busy, e_alu, e_we, e_done, e_ab, iss;
    p      = k + int'(RD_LAT) + int'(PE_LAT) + 1;
    t_all  = tiles * p;
    c_end  = (term_at > 0) ? term_at + 1 : t_all + 1;
    cfg_k      = CW'(k);
    cfg_tiles  = (O_AW+1)'(tiles);
    cfg_w_base = W_AW'(wb);
    cfg_v_base = V_AW'(vb);
    cfg_o_base = O_AW'(ob);
    start = 1'b1;
    abort = 1'b0;
    srst  = 1'b0;
    for (int c = 1; c <= c_end; c++) begin
      tick();
      cur_c = c;
      term  = (term_at > 0) && (c > term_at);
      iss = 1'b0; e_w = 0; e_v = 0; e_num = 0; e_wa = 0; e_we = 1'b0;
      e_alu = 1'b0; e_done = 1'b0; e_ab = 1'b0; e_busy = 1'b0; e_tile = -1;
      if (term) begin
        e_ab   = !term_rst;
        e_tile = term_rst ? 0 : -1;
      end else if (c <= t_all) begin
        off    = (c - 1) % p;
        t      = (c - 1) / p;
        e_busy = 1'b1;
        iss    = (off < k);
        e_w    = (wb + t * k + off) % (1 << W_AW);
        e_v    = (vb + off) % (1 << V_AW);
        e_alu  = (off >= int'(RD_LAT)) && (off < k + int'(RD_LAT));
        e_num  = e_alu ? off - int'(RD_LAT) + 1 : 0;
        e_we   = (off == p - 1);
        e_wa   = (ob + t) % (1 << O_AW);
        e_tile = t;
      end else begin
        e_done = 1'b1;
        e_tile = tiles - 1;
      end
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("aborted", 32'(aborted), 32'(e_ab));
      chk("err_cfg", 32'(err_cfg), 32'd0);
      chk("alu_start", 32'(alu_start), 32'(e_alu));
      chk("cycle_num", 32'(cycle_num), 32'(e_num));
      chk("outcome_we", 32'(outcome_we), 32'(e_we));
      if (e_we) chk("outcome_waddr", 32'(outcome_waddr), 32'(e_wa));
      if (iss) begin
        chk("sram_w_raddr", 32'(sram_w_raddr), 32'(e_w));
        chk("sram_v_raddr", 32'(sram_v_raddr), 32'(e_v));
      end
      if (e_tile >= 0) chk("tile_idx", 32'(tile_idx), 32'(e_tile));
      // inputs for the current cycle: config churn and stray starts while busy
      rand_cfg();
      if (c == c_end) begin
        start = hold;
        abort = 1'b0;
        srst  = 1'b0;
      end else begin
        start = 1'($urandom);
        abort = !term_rst && (c == term_at);
        srst  = term_rst && (c == term_at);
      end
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_alu", 32'(alu_start), 32'd0);
      chk("idle_we", 32'(outcome_we), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_aborted", 32'(aborted), 32'd0);
    end
  endtask

  task automatic bad_cfg(input int k, input int tiles);
    rand_cfg();
    cfg_k     = CW'(k);
    cfg_tiles = (O_AW+1)'(tiles);
    start = 1'b1;
    abort = 1'b0;
    tick();
    chk("bad_err", 32'(err_cfg), 32'd1);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_alu", 32'(alu_start), 32'd0);
    chk("bad_we", 32'(outcome_we), 32'd0);
    start = 1'b0;
    tick();
    chk("bad_err_clr", 32'(err_cfg), 32'd0);
    chk("bad_busy2", 32'(busy), 32'd0);
    chk("bad_alu2", 32'(alu_start), 32'd0);
  endtask

  initial begin
    int k, tiles, p, ta;
    bit tr, hd;
    srst = 1'b1; start = 1'b0; abort = 1'b0;
    rand_cfg();
    @(negedge clk);
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_err", 32'(err_cfg), 32'd0);
    chk("rst_w", 32'(sram_w_raddr), 32'd0);
    chk("rst_v", 32'(sram_v_raddr), 32'd0);
    chk("rst_alu", 32'(alu_start), 32'd0);
    chk("rst_num", 32'(cycle_num), 32'd0);
    chk("rst_we", 32'(outcome_we), 32'd0);
    chk("rst_waddr", 32'(outcome_waddr), 32'd0);
    chk("rst_tile", 32'(tile_idx), 32'd0);
    srst = 1'b0;
    idle(2);

    // reference two-tile job
    run_job(4, 2, 0, 8, 3, 1'b0, 0, 1'b0);
    idle(2);
    chk("tile_hold", 32'(tile_idx), 32'd1);

    // illegal configurations
    bad_cfg(0, 1);
    bad_cfg(int'(MAX_K) + 1, 1);
    bad_cfg(4, 0);
    bad_cfg(4, (1 << O_AW) + 1);

    // maximum depth, and maximum tile count
    run_job(int'(MAX_K), 1, 3, 100, 7, 1'b0, 0, 1'b0);
    idle(1);
    run_job(1, 1 << O_AW, 5, 1, 2, 1'b0, 0, 1'b0);
    idle(1);

    // abort during second tile's issue, then a clean job
    run_job(4, 2, 0, 8, 3, 1'b0, 10, 1'b0);
    idle(1);
    run_job(4, 2, 0, 8, 3, 1'b0, 0, 1'b0);
    idle(1);

    // address wrap
    run_job(4, 2, 14, 1022, 31, 1'b0, 0, 1'b0);
    idle(1);

    // start held continuously: relaunch only from IDLE after done
    run_job(3, 2, 2, 9, 4, 1'b1, 0, 1'b0);
    run_job(2, 1, 6, 50, 30, 1'b1, 0, 1'b0);
    run_job(5, 1, 1, 3, 0, 1'b0, 0, 1'b0);
    idle(1);

    // abort together with start in IDLE: abort wins, no acknowledge
    cfg_k = CW'(4); cfg_tiles = (O_AW+1)'(1);
    start = 1'b1; abort = 1'b1;
    tick();
    chk("ab_idle_busy", 32'(busy), 32'd0);
    chk("ab_idle_aborted", 32'(aborted), 32'd0);
    idle(1);

    // synchronous reset mid-job
    run_job(5, 3, 4, 20, 9, 1'b0, 7, 1'b1);
    idle(2);

    // randomized jobs
    for (int n = 0; n < 30; n++) begin
      k     = $urandom_range(1, 10);
      tiles = $urandom_range(1, 5);
      p     = k + int'(RD_LAT) + int'(PE_LAT) + 1;
      ta    = 0;
      tr    = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        ta = $urandom_range(1, tiles * p);
        tr = ($urandom_range(0, 2) == 0);
      end
      hd = 1'($urandom);
      run_job(k, tiles, int'($urandom_range(0, 15)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 31)), hd, ta, tr);
      if (!hd) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
